cpa_stim_gen: RTL and testbench
===============================

Name: cpa_stim_gen

Overview:
- Parametrised stimulus sequencer for CPA/TVLA trace campaigns.
- Produces a plaintext/key pair per trace and handshakes it into the cipher core.
- Waits for cipher completion, inserts a programmable quiet gap for trace alignment, and counts traces to a programmed total.
- Supports four key/text modes, including fixed-vs-random interleave for TVLA.

Parameters:
TEXT_W, 128, plaintext width (>=8)
KEY_W, 128, key width (>=8)
CNT_W, 16, trace counter / num_traces width
TEXT_TAPS, 128'h14000003, text LFSR tap mask (TEXT_W bits)
KEY_TAPS, 128'h14000003, key LFSR tap mask (KEY_W bits)
TEXT_SEED, 1, text LFSR reset value (0 replaced by 1)
KEY_SEED, 1, key LFSR reset value (0 replaced by 1)
FIXED_TEXT, 0, plaintext used by fixed-text classes
FIXED_KEY, 1, key used by fixed-key modes
GAP_CYCLES, 4, idle cycles between ct_done and next trace generation (0 allowed)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
ena  in  1  global run enable; low freezes FSM, counters, LFSRs
start  in  1  pulse: begin campaign (ignored unless IDLE)
abort  in  1  return to IDLE from any state
mode  in  2  0 fixed key/random text; 1 random key/random text; 2 fixed-vs-random text, fixed key; 3 fixed text/fixed key
num_traces  in  CNT_W  traces per campaign, latched on start
out_ready  in  1  cipher accepts plaintext/key
ct_done  in  1  cipher finished current trace
plainText  out  TEXT_W  plaintext to cipher
cypher_key  out  KEY_W  key to cipher
out_valid  out  1  plaintext/key valid
trace_idx  out  CNT_W  index of presented trace (0-based)
trace_class  out  1  0 = fixed class, 1 = random class
busy  out  1  campaign in progress
done  out  1  one-cycle pulse at campaign end

Behaviour:
- Reset (reset_n low, async): state IDLE; all outputs 0; text/key LFSRs = seeds; latched mode/num = 0.
- Both LFSRs are Fibonacci: next = {s[W-2:0], ^(s & TAPS)}. An all-zero state reloads 1. LFSRs are never reset by start; they persist across campaigns.
- States: IDLE, GEN, PRESENT, WAIT_CT, GAP, FIN.
- ena=0: state, counters, LFSRs and all outputs hold; done pulse is not extended (done still drops after one ena=1 cycle); inputs ignored except abort and reset_n.
- IDLE:
  - start=1 latches mode and num_traces and clears trace counter.
  - busy=1 from the next cycle.
  - Go to GEN if num_traces!=0, else FIN.
- GEN (1 cycle): load outputs per mode, advance LFSRs; next state PRESENT.
  - mode 0: text LFSR advances; plainText = advanced value; key = FIXED_KEY; class = 1.
  - mode 1: both LFSRs advance; outputs = advanced values; class = 1.
  - mode 2, even idx: plainText = FIXED_TEXT, class = 0, no advance.
  - mode 2, odd idx: text LFSR advances, plainText = advanced value, class = 1.
  - mode 2 key: FIXED_KEY.
  - mode 3: FIXED_TEXT/FIXED_KEY; class = 0; no advance.
  - trace_idx = counter.
- PRESENT: out_valid=1; plainText/cypher_key stable until acceptance.
  - out_valid & out_ready -> WAIT_CT; out_valid=0 next cycle.
- WAIT_CT: on ct_done, counter+1.
  - If counter+1 == latched num -> FIN.
  - Else if GAP_CYCLES=0 -> GEN.
  - Else -> GAP.
  - ct_done in any other state is ignored.
- GAP: count GAP_CYCLES cycles, then GEN. Counter clears on entry.
- FIN (1 cycle): done=1, busy=0 next cycle; return to IDLE.
- abort (any state, ena irrelevant): next state IDLE; out_valid=0, busy=0, no done. Data outputs hold last value; LFSRs keep state.
- Simultaneous start and abort: abort wins. start during busy: ignored.
- Counter wraps never: num_traces max = 2^CNT_W-1.
- Latency: start -> first out_valid = 2 cycles.

Test Plan:
- Reset, then run with TEXT_W=8, TEXT_TAPS=8'hB8, TEXT_SEED=1, mode 0, num 3, out_ready=1, ct_done 2 cycles after acceptance, GAP_CYCLES=4 -> plaintexts 02, 04, 08; key FIXED_KEY; trace_idx 0,1,2; 4-cycle gaps; done one pulse; busy falls with done.
- Mode 2, num 4, same LFSR -> plaintexts FIXED_TEXT, 02, FIXED_TEXT, 04; trace_class 0,1,0,1.
- out_ready held low 10 cycles in PRESENT -> out_valid stays high; data stable throughout; accepted on first out_ready cycle.
- abort asserted in WAIT_CT mid-campaign -> IDLE next cycle, no done. A new start continues LFSR sequence (next plaintext 0x11 after 08).
- num_traces=0 with start -> no out_valid; done pulses 2 cycles after start.
- ena deasserted 5 cycles during GAP, and start issued while busy -> gap extends by 5 cycles; the busy-time start is ignored. reset_n low mid-PRESENT -> all outputs 0 immediately.

Source files
------------

// File: rtl/cpa_stim_gen.sv
// cpa_stim_gen: plaintext/key sequencer for CPA/TVLA trace campaigns.
// Generates one plaintext/key pair per trace, hands it to the cipher core
// with a valid/ready handshake, waits for completion, then inserts a quiet
// gap so consecutive traces line up. Text and key sources are Fibonacci LFSRs
// that persist across campaigns, so every campaign draws fresh values.
module cpa_stim_gen #(
  parameter int unsigned       TEXT_W     = 128,
  parameter int unsigned       KEY_W      = 128,
  parameter int unsigned       CNT_W      = 16,
  parameter logic [TEXT_W-1:0] TEXT_TAPS  = 'h14000003,
  parameter logic [KEY_W-1:0]  KEY_TAPS   = 'h14000003,
  parameter logic [TEXT_W-1:0] TEXT_SEED  = 'h1,
  parameter logic [KEY_W-1:0]  KEY_SEED   = 'h1,
  parameter logic [TEXT_W-1:0] FIXED_TEXT = '0,
  parameter logic [KEY_W-1:0]  FIXED_KEY  = 'h1,
  parameter int unsigned       GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ena,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  num_traces,
  input  logic              out_ready,
  input  logic              ct_done,
  output logic [TEXT_W-1:0] plainText,
  output logic [KEY_W-1:0]  cypher_key,
  output logic              out_valid,
  output logic [CNT_W-1:0]  trace_idx,
  output logic              trace_class,
  output logic              busy,
  output logic              done
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [TEXT_W-1:0] TEXT_ONE  = TEXT_W'(1);
  localparam logic [KEY_W-1:0]  KEY_ONE   = KEY_W'(1);
  localparam logic [TEXT_W-1:0] TEXT_INIT = (TEXT_SEED == '0) ? TEXT_ONE : TEXT_SEED;
  localparam logic [KEY_W-1:0]  KEY_INIT  = (KEY_SEED == '0) ? KEY_ONE : KEY_SEED;

  // Gap counter runs 0 .. GAP_CYCLES-1; kept at least one bit wide.
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_PRESENT, S_WAIT_CT, S_GAP, S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [TEXT_W-1:0]   text_lfsr_q, text_lfsr_d, text_step;
  logic [KEY_W-1:0]    key_lfsr_q, key_lfsr_d, key_step;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [TEXT_W-1:0]   plain_q, plain_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                class_q, class_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // One Fibonacci step for each LFSR; an all-zero state recovers to 1.
  always_comb begin
    text_step = (text_lfsr_q == '0) ? TEXT_ONE
              : {text_lfsr_q[TEXT_W-2:0], ^(text_lfsr_q & TEXT_TAPS)};
    key_step  = (key_lfsr_q == '0) ? KEY_ONE
              : {key_lfsr_q[KEY_W-2:0], ^(key_lfsr_q & KEY_TAPS)};
    cnt_inc   = cnt_q + CNT_W'(1);
  end

  // Next-state and output logic of the campaign FSM.
  always_comb begin
    state_d     = state_q;
    text_lfsr_d = text_lfsr_q;
    key_lfsr_d  = key_lfsr_q;
    mode_d      = mode_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    plain_d     = plain_q;
    key_d       = key_q;
    valid_d     = valid_q;
    idx_d       = idx_q;
    class_d     = class_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          num_d   = num_traces;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (num_traces != '0) ? S_GEN : S_FIN;
        end
      end

      S_GEN: begin
        state_d = S_PRESENT;
        valid_d = 1'b1;
        idx_d   = cnt_q;
        case (mode_q)
          2'd0: begin
            text_lfsr_d = text_step;
            plain_d     = text_step;
            key_d       = FIXED_KEY;
            class_d     = 1'b1;
          end
          2'd1: begin
            text_lfsr_d = text_step;
            key_lfsr_d  = key_step;
            plain_d     = text_step;
            key_d       = key_step;
            class_d     = 1'b1;
          end
          2'd2: begin
            // TVLA interleave: even traces fixed class, odd traces random.
            key_d = FIXED_KEY;
            if (cnt_q[0]) begin
              text_lfsr_d = text_step;
              plain_d     = text_step;
              class_d     = 1'b1;
            end else begin
              plain_d = FIXED_TEXT;
              class_d = 1'b0;
            end
          end
          default: begin
            plain_d = FIXED_TEXT;
            key_d   = FIXED_KEY;
            class_d = 1'b0;
          end
        endcase
      end

      S_PRESENT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT_CT;
        end
      end

      S_WAIT_CT: begin
        if (ct_done) begin
          cnt_d = cnt_inc;
          gap_d = '0;
          if (cnt_inc == num_q)    state_d = S_FIN;
          else if (GAP_CYCLES == 0) state_d = S_GEN;
          else                      state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) state_d = S_GEN;
        else                           gap_d   = gap_q + GAP_W'(1);
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register: abort overrides ena; ena low freezes everything else.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      text_lfsr_q <= TEXT_INIT;
      key_lfsr_q  <= KEY_INIT;
      mode_q      <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      plain_q     <= '0;
      key_q       <= '0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      class_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      text_lfsr_q <= text_lfsr_d;
      key_lfsr_q  <= key_lfsr_d;
      mode_q      <= mode_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      plain_q     <= plain_d;
      key_q       <= key_d;
      valid_q     <= valid_d;
      idx_q       <= idx_d;
      class_q     <= class_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign plainText   = plain_q;
  assign cypher_key  = key_q;
  assign out_valid   = valid_q;
  assign trace_idx   = idx_q;
  assign trace_class = class_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cpa_stim_gen.sv
// Directed testbench for cpa_stim_gen with 8-bit text/key LFSRs (taps B8).
`timescale 1ns/1ps
module tb_cpa_stim_gen;

  localparam int         TW  = 8;
  localparam int         KW  = 8;
  localparam int         CW  = 8;
  localparam int         GAP = 4;
  localparam logic [7:0] FT  = 8'hA5;
  localparam logic [7:0] FK  = 8'h3C;

  logic          clk = 1'b0;
  logic          reset_n, ena, start, abort, out_ready, ct_done;
  logic [1:0]    mode;
  logic [CW-1:0] num_traces;
  logic [TW-1:0] plainText;
  logic [KW-1:0] cypher_key;
  logic          out_valid;
  logic [CW-1:0] trace_idx;
  logic          trace_class, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpa_stim_gen #(
    .TEXT_W(TW), .KEY_W(KW), .CNT_W(CW),
    .TEXT_TAPS(8'hB8), .KEY_TAPS(8'hB8),
    .TEXT_SEED(8'h01), .KEY_SEED(8'h05),
    .FIXED_TEXT(FT), .FIXED_KEY(FK),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .start(start), .abort(abort),
    .mode(mode), .num_traces(num_traces), .out_ready(out_ready), .ct_done(ct_done),
    .plainText(plainText), .cypher_key(cypher_key), .out_valid(out_valid),
    .trace_idx(trace_idx), .trace_class(trace_class), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_campaign(input logic [1:0] m, input logic [CW-1:0] n);
    mode       = m;
    num_traces = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Wait (bounded) for out_valid; optionally check how many cycles it took.
  task automatic wait_valid(input string tag, input int exp_n);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    if (exp_n >= 0) chk({tag, "_wait"}, n, exp_n);
  endtask

  // Check presented trace, optionally stall, accept, then ct_done 2 cycles later.
  task automatic serve(input string tag, input logic [7:0] exp_pt, input logic [7:0] exp_key,
                       input int exp_idx, input logic exp_cls, input int stall, input bit do_ct);
    chk({tag, "_pt"}, plainText, exp_pt);
    chk({tag, "_key"}, cypher_key, exp_key);
    chk({tag, "_idx"}, trace_idx, exp_idx);
    chk({tag, "_class"}, trace_class, exp_cls);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_pt"}, plainText, exp_pt);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_accept"}, out_valid, 0);
    $display("trace %s: idx=%0d pt=%02h key=%02h class=%0d", tag, trace_idx, plainText,
             cypher_key, trace_class);
    if (do_ct) begin
      tick();
      ct_done = 1'b1;
      tick();
      ct_done = 1'b0;
    end
  endtask

  // Called one cycle into FIN: done pulses for one cycle, busy falls with it.
  task automatic done_seq(input string tag);
    chk({tag, "_busy_pre"}, busy, 1);
    chk({tag, "_done_pre"}, done, 0);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_valid_end"}, out_valid, 0);
    tick();
    chk({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    reset_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
    num_traces = '0; out_ready = 1'b0; ct_done = 1'b0;
    repeat (2) tick();
    chk("rst_pt", plainText, 0);
    chk("rst_key", cypher_key, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", trace_idx, 0);
    chk("rst_class", trace_class, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    tick();

    // Mode 0, three traces: 02, 04, 08 with four-cycle gaps.
    start_campaign(2'd0, 3);
    chk("c1_busy", busy, 1);
    chk("c1_valid_early", out_valid, 0);
    tick();
    chk("c1_latency", out_valid, 1);
    serve("c1t0", 8'h02, FK, 0, 1'b1, 0, 1);
    wait_valid("c1t1", GAP + 1);
    serve("c1t1", 8'h04, FK, 1, 1'b1, 0, 1);
    wait_valid("c1t2", GAP + 1);
    serve("c1t2", 8'h08, FK, 2, 1'b1, 0, 1);
    done_seq("c1");

    // LFSR continues across campaigns; ready stalled 10 cycles; abort in WAIT_CT.
    start_campaign(2'd0, 2);
    wait_valid("c2t0", 1);
    serve("c2t0", 8'h11, FK, 0, 1'b1, 10, 0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_pt_hold", plainText, 8'h11);
    ct_done = 1'b1;
    tick();
    ct_done = 1'b0;
    chk("idle_ctdone_busy", busy, 0);
    tick();
    chk("idle_ctdone_done", done, 0);
    start_campaign(2'd0, 1);
    wait_valid("c3t0", 1);
    serve("c3t0", 8'h23, FK, 0, 1'b1, 0, 1);
    done_seq("c3");

    // Fresh reset, mode 2 interleave, ena pause in the first gap with a busy-time start.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    start_campaign(2'd2, 4);
    wait_valid("c4t0", 1);
    serve("c4t0", FT, FK, 0, 1'b0, 0, 1);
    ena = 1'b0; start = 1'b1; mode = 2'd3; num_traces = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pause_valid", out_valid, 0);
    end
    ena = 1'b1; start = 1'b0;
    chk("pause_busy", busy, 1);
    wait_valid("c4t1", GAP + 1);
    serve("c4t1", 8'h02, FK, 1, 1'b1, 0, 1);
    wait_valid("c4t2", GAP + 1);
    serve("c4t2", FT, FK, 2, 1'b0, 0, 1);
    wait_valid("c4t3", GAP + 1);
    serve("c4t3", 8'h04, FK, 3, 1'b1, 0, 1);
    done_seq("c4");

    // num_traces = 0: straight to FIN, no trace presented.
    start_campaign(2'd0, 0);
    chk("c5_valid", out_valid, 0);
    done_seq("c5");

    // Mode 1: both LFSRs advance (text 04->08, key 05->0A).
    start_campaign(2'd1, 1);
    wait_valid("c6t0", 1);
    serve("c6t0", 8'h08, 8'h0A, 0, 1'b1, 0, 1);
    done_seq("c6");

    // Mode 3: fixed text and key, fixed class.
    start_campaign(2'd3, 1);
    wait_valid("c7t0", 1);
    serve("c7t0", FT, FK, 0, 1'b0, 0, 1);
    done_seq("c7");

    // Reset asserted mid-PRESENT clears outputs without waiting for a clock.
    start_campaign(2'd0, 2);
    wait_valid("c8t0", 1);
    chk("c8_pt", plainText, 8'h11);
    #4;
    reset_n = 1'b0;
    #1;
    chk("arst_pt", plainText, 0);
    chk("arst_key", cypher_key, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_class", trace_class, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
